// File: rtl/weapon_fire_sequencer_pkg.sv
// Shared types and constants for the weapon fire sequencer.
//   AMMO_W / FRAME_W / TIMER_W : widths of the ammo count, sprite index and phase timer
//   state_e                    : sequencer states
//   Ws*                        : one-hot weapon_state codes presented to the renderer
//   ws_of()                    : maps a state to its weapon_state code
package weapon_fire_sequencer_pkg;

  localparam int unsigned AMMO_W  = 4;
  localparam int unsigned FRAME_W = 3;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFire,
    StAnim,
    StCooldown,
    StHold,
    StReload
  } state_e;

  localparam logic [2:0] WsReady  = 3'b001;
  localparam logic [2:0] WsFiring = 3'b010;
  localparam logic [2:0] WsBusy   = 3'b100;

  function automatic logic [2:0] ws_of(input state_e st);
    case (st)
      StIdle:  ws_of = WsReady;
      StFire:  ws_of = WsFiring;
      default: ws_of = WsBusy;
    endcase
  endfunction

endpackage

// File: rtl/weapon_fire_sequencer_tick_timer.sv
// Shared down-counter for the animation, cooldown and reload phases.
// Counts tick pulses only; a load takes priority over a tick in the same cycle,
// so the tick is dropped. Holds at zero once expired.
//   clk_i     : system clock
//   rst_ni    : synchronous active-low reset, clears the count
//   load_i    : load value_i into the counter
//   value_i   : load value (tick count)
//   tick_i    : frame-rate strobe
//   expired_o : count is zero
module weapon_fire_sequencer_tick_timer
  import weapon_fire_sequencer_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] value_i,
  input  logic               tick_i,
  output logic               expired_o
);

  logic [TIMER_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/weapon_fire_sequencer.sv
// Weapon fire sequencer: trigger -> one-clk FIRE -> timed sprite animation ->
// cooldown -> hold until release; reload on request. Tracks ammo and raises a
// req/ack hit request when the enemy is in sight during FIRE.
// Optional macro AUTO_FIRE_EN: a held trigger re-fires straight from HOLD.
//   clk_i            : system clock
//   rst_ni           : synchronous active-low reset
//   tick_i           : frame-rate strobe, all phase timing counts these
//   trigger_i        : debounced fire switch (level)
//   reload_btn_i     : debounced reload button (level)
//   enemy_in_sight_i : crosshair on enemy, sampled in FIRE
//   hit_ack_i        : enemy logic accepted the hit
//   hit_req_o        : pending hit request
//   weapon_state_o   : one-hot 001 ready / 010 firing / 100 busy
//   anim_frame_o     : 0 idle sprite, 1..ANIM_FRAMES while animating
//   ammo_o           : rounds remaining
//   empty_o          : no rounds left
//   reloading_o      : reload in progress
module weapon_fire_sequencer
  import weapon_fire_sequencer_pkg::*;
#(
  parameter int unsigned AMMO_MAX       = 8,
  parameter int unsigned ANIM_FRAMES    = 4,
  parameter int unsigned FRAME_TICKS    = 3,
  parameter int unsigned COOLDOWN_TICKS = 6,
  parameter int unsigned RELOAD_TICKS   = 30
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic               trigger_i,
  input  logic               reload_btn_i,
  input  logic               enemy_in_sight_i,
  input  logic               hit_ack_i,
  output logic               hit_req_o,
  output logic [2:0]         weapon_state_o,
  output logic [FRAME_W-1:0] anim_frame_o,
  output logic [AMMO_W-1:0]  ammo_o,
  output logic               empty_o,
  output logic               reloading_o
);

  localparam logic [AMMO_W-1:0]  AmmoMax    = AMMO_W'(AMMO_MAX);
  localparam logic [FRAME_W-1:0] AnimFrames = FRAME_W'(ANIM_FRAMES);
  localparam logic [TIMER_W-1:0] FrameTicks = TIMER_W'(FRAME_TICKS);
  localparam logic [TIMER_W-1:0] CoolTicks  = TIMER_W'(COOLDOWN_TICKS);
  localparam logic [TIMER_W-1:0] RelTicks   = TIMER_W'(RELOAD_TICKS);

  state_e             state_d, state_q;
  logic [2:0]         ws_q;
  logic [AMMO_W-1:0]  ammo_d, ammo_q;
  logic [FRAME_W-1:0] frame_d, frame_q;
  logic               hit_req_d, hit_req_q;
  logic               reloading_q;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_expired;

  weapon_fire_sequencer_tick_timer u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .tick_i    (tick_i),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    ammo_d    = ammo_q;
    frame_d   = frame_q;
    hit_req_d = hit_req_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    if (hit_req_q && hit_ack_i) begin
      hit_req_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        // A pending hit blocks a new shot, so set and clear never collide.
        if (trigger_i && (ammo_q != '0) && !hit_req_q) begin
          state_d = StFire;
        end else if (reload_btn_i && (ammo_q < AmmoMax)) begin
          state_d   = StReload;
          tmr_load  = 1'b1;
          tmr_value = RelTicks;
        end
      end
      StFire: begin
        ammo_d    = ammo_q - AMMO_W'(1);
        frame_d   = FRAME_W'(1);
        tmr_load  = 1'b1;
        tmr_value = FrameTicks;
        state_d   = StAnim;
        if (enemy_in_sight_i) begin
          hit_req_d = 1'b1;
        end
      end
      StAnim: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          if (frame_q < AnimFrames) begin
            frame_d   = frame_q + FRAME_W'(1);
            tmr_value = FrameTicks;
          end else begin
            frame_d   = '0;
            tmr_value = CoolTicks;
            state_d   = StCooldown;
          end
        end
      end
      StCooldown: begin
        if (tmr_expired) begin
          state_d = StHold;
        end
      end
      StHold: begin
`ifdef AUTO_FIRE_EN
        if (!trigger_i) begin
          state_d = StIdle;
        end else if ((ammo_q != '0) && !hit_req_q) begin
          state_d = StFire;
        end
`else
        if (!trigger_i) begin
          state_d = StIdle;
        end
`endif
      end
      StReload: begin
        if (tmr_expired) begin
          ammo_d  = AmmoMax;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ws_q        <= WsReady;
      ammo_q      <= AmmoMax;
      frame_q     <= '0;
      hit_req_q   <= 1'b0;
      reloading_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_of(state_d);
      ammo_q      <= ammo_d;
      frame_q     <= frame_d;
      hit_req_q   <= hit_req_d;
      reloading_q <= (state_d == StReload);
    end
  end

  assign hit_req_o      = hit_req_q;
  assign weapon_state_o = ws_q;
  assign anim_frame_o   = frame_q;
  assign ammo_o         = ammo_q;
  assign empty_o        = (ammo_q == '0);
  assign reloading_o    = reloading_q;

endmodule

// File: tb/tb_weapon_fire_sequencer.sv
// Self-checking bench for weapon_fire_sequencer: directed scenarios followed by
// random traffic, every cycle compared against a behavioural model of the
// weapon (phase + ticks remaining + ammo + pending hit).
module tb_weapon_fire_sequencer;

  localparam int AmmoMax    = 8;
  localparam int AnimFrames = 4;
  localparam int FrameTicks = 3;
  localparam int CoolTicks  = 6;
  localparam int RelTicks   = 30;

  logic       clk, rst_n, tick, trigger, reload_btn, enemy, hit_ack;
  logic       hit_req, empty, reloading;
  logic [2:0] ws, frame;
  logic [3:0] ammo;

  weapon_fire_sequencer #(
    .AMMO_MAX       (AmmoMax),
    .ANIM_FRAMES    (AnimFrames),
    .FRAME_TICKS    (FrameTicks),
    .COOLDOWN_TICKS (CoolTicks),
    .RELOAD_TICKS   (RelTicks)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .tick_i           (tick),
    .trigger_i        (trigger),
    .reload_btn_i     (reload_btn),
    .enemy_in_sight_i (enemy),
    .hit_ack_i        (hit_ack),
    .hit_req_o        (hit_req),
    .weapon_state_o   (ws),
    .anim_frame_o     (frame),
    .ammo_o           (ammo),
    .empty_o          (empty),
    .reloading_o      (reloading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Behavioural model: which phase the weapon is in and how many ticks remain.
  localparam int PhReady = 0, PhFire = 1, PhAnim = 2, PhCool = 3, PhHold = 4, PhReload = 5;
  int m_ph, m_left, m_frame, m_ammo;
  bit m_hit;

  task automatic model_reset();
    m_ph = PhReady; m_left = 0; m_frame = 0; m_ammo = AmmoMax; m_hit = 0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_edge();
    bit was_hit = m_hit;
    bit set_hit = 0;
    int nxt = m_ph;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_ph)
      PhReady:
        if (trigger && m_ammo > 0 && !was_hit) nxt = PhFire;
        else if (reload_btn && m_ammo < AmmoMax) begin nxt = PhReload; m_left = RelTicks; end
      PhFire: begin
        m_ammo--; set_hit = enemy; m_frame = 1; m_left = FrameTicks; nxt = PhAnim;
      end
      PhAnim:
        if (m_left == 0) begin
          if (m_frame < AnimFrames) begin m_frame++; m_left = FrameTicks; end
          else begin m_frame = 0; m_left = CoolTicks; nxt = PhCool; end
        end else if (tick) m_left--;
      PhCool:
        if (m_left == 0) nxt = PhHold;
        else if (tick) m_left--;
      PhHold: begin
        if (!trigger) nxt = PhReady;
`ifdef AUTO_FIRE_EN
        else if (m_ammo > 0 && !was_hit) nxt = PhFire;
`endif
      end
      PhReload:
        if (m_left == 0) begin m_ammo = AmmoMax; nxt = PhReady; end
        else if (tick) m_left--;
      default: nxt = PhReady;
    endcase
    if (was_hit && hit_ack) m_hit = 0;
    if (set_hit) m_hit = 1;
    m_ph = nxt;
  endtask

  task automatic step();
    int exp_ws;
    @(posedge clk);
    model_edge();
    #1;
    exp_ws = (m_ph == PhReady) ? 1 : (m_ph == PhFire) ? 2 : 4;
    check_eq("weapon_state", int'(ws), exp_ws);
    check_eq("anim_frame", int'(frame), m_frame);
    check_eq("ammo", int'(ammo), m_ammo);
    check_eq("empty", int'(empty), int'(m_ammo == 0));
    check_eq("reloading", int'(reloading), int'(m_ph == PhReload));
    check_eq("hit_req", int'(hit_req), int'(m_hit));
    // Single-clk tick strobes at a random rate.
    tick = !tick && ($urandom_range(0, 1) == 1);
  endtask

  task automatic run_until(input string tag, input int ph, input int bound);
    int n = 0;
    while (m_ph != ph && n < bound) begin
      step();
      n++;
    end
    check_eq(tag, m_ph, ph);
  endtask

  task automatic shoot();
    trigger = 1;
    run_until("shoot_hold", PhHold, 400);
    trigger = 0;
    run_until("shoot_idle", PhReady, 5);
  endtask

  initial begin
    model_reset();
    rst_n = 0; tick = 0; trigger = 0; reload_btn = 0; enemy = 0; hit_ack = 0;
    step(); step();
    check_eq("rst_state", int'(ws), 1);
    check_eq("rst_ammo", int'(ammo), AmmoMax);
    check_eq("rst_hit_req", int'(hit_req), 0);
    rst_n = 1;

    // Single shot with enemy in sight, ack withheld.
    trigger = 1; enemy = 1;
    step();
    check_eq("t1_firing", int'(ws), 2);
    step();
    check_eq("t1_busy", int'(ws), 4);
    check_eq("t1_ammo", int'(ammo), 7);
    check_eq("t1_hit_req", int'(hit_req), 1);
    check_eq("t1_frame", int'(frame), 1);
    run_until("t1_hold", PhHold, 400);
    check_eq("t1_frame_idle", int'(frame), 0);
    repeat (100) step();
    check_eq("t3_hit_held", int'(hit_req), 1);
    check_eq("t1_still_hold", int'(ws), 4);

    // New press while the hit is still pending must wait for the ack.
    trigger = 0; step();
    trigger = 1;
    repeat (10) step();
    check_eq("t3_blocked", int'(ws), 1);
    hit_ack = 1; step();
    check_eq("t3_cleared", int'(hit_req), 0);
    step();
    check_eq("t3_fire_after_ack", int'(ws), 2);
    enemy = 0;
    run_until("t3_hold", PhHold, 400);
    trigger = 0;
    run_until("t3_idle", PhReady, 5);

    // Empty the magazine, try a dry fire, then reload.
    for (int i = 0; i < 12 && m_ammo > 0; i++) shoot();
    check_eq("t2_ammo_zero", int'(ammo), 0);
    check_eq("t2_empty", int'(empty), 1);
    trigger = 1;
    repeat (20) step();
    check_eq("t2_no_fire", int'(ws), 1);
    trigger = 0; reload_btn = 1;
    step();
    check_eq("t2_reloading", int'(reloading), 1);
    reload_btn = 0;
    run_until("t2_reload_done", PhReady, 400);
    check_eq("t2_ammo_full", int'(ammo), AmmoMax);

    // Reset mid-animation and mid-reload.
    enemy = 1; trigger = 1;
    repeat (4) step();
    trigger = 0; rst_n = 0;
    step();
    rst_n = 1;
    check_eq("t4_anim_ammo", int'(ammo), AmmoMax);
    check_eq("t4_anim_frame", int'(frame), 0);
    check_eq("t4_anim_hit", int'(hit_req), 0);
    check_eq("t4_anim_ws", int'(ws), 1);
    shoot();
    reload_btn = 1; step(); reload_btn = 0;
    repeat (10) step();
    check_eq("t4_mid_reload", int'(reloading), 1);
    rst_n = 0; step(); rst_n = 1;
    check_eq("t4_rel_ammo", int'(ammo), AmmoMax);
    check_eq("t4_rel_reloading", int'(reloading), 0);
    check_eq("t4_rel_ws", int'(ws), 1);

    // Trigger beats reload; reload with a full magazine does nothing.
    repeat (3) shoot();
    check_eq("t5_ammo5", int'(ammo), 5);
    trigger = 1; reload_btn = 1;
    step();
    check_eq("t5_fire_wins", int'(ws), 2);
    step();
    check_eq("t5_ammo4", int'(ammo), 4);
    trigger = 0; reload_btn = 0;
    run_until("t5_idle", PhReady, 400);
    rst_n = 0; step(); rst_n = 1;
    reload_btn = 1;
    repeat (5) step();
    check_eq("t5_no_reload", int'(reloading), 0);
    reload_btn = 0;

    // Random traffic against the model.
    repeat (3000) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0) trigger = ~trigger;
      if ($urandom_range(0, 9) == 0) reload_btn = ~reload_btn;
      enemy   = $urandom_range(0, 1) == 1;
      hit_ack = $urandom_range(0, 3) == 0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
